// File: rtl/alu_step_sequencer_if.sv
// Control interface between the step sequencer (master) and the Datapath_P2 datapath (slave).
// The Step input exists only when SINGLE_STEP_EN is defined.
interface alu_step_sequencer_if #(
  parameter int IR_W  = 32,
  parameter int OPC_W = 5
);
`ifdef SINGLE_STEP_EN
  logic             Step;
`endif
  logic             Run;
  logic             MemReady;
  logic [IR_W-1:0]  Instr;

  logic             PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic             Gra, Grb, Grc, Rin, Rout, Yin, Cout;
  logic [OPC_W-1:0] AluOp;
  logic             Busy, Done, Fault;

  modport master (
`ifdef SINGLE_STEP_EN
    input  Step,
`endif
    input  Run, MemReady, Instr,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    output Gra, Grb, Grc, Rin, Rout, Yin, Cout,
    output AluOp, Busy, Done, Fault
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output Step,
`endif
    output Run, MemReady, Instr,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    input  Gra, Grb, Grc, Rin, Rout, Yin, Cout,
    input  AluOp, Busy, Done, Fault
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// Hardwired T0..T5 control-step sequencer with memory-ready timeout and continuous run.
// Define SINGLE_STEP_EN to add a HOLD state released by the Step input.
module alu_step_sequencer #(
  parameter int IR_W     = 32,
  parameter int OPC_W    = 5,
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 8
) (
  input  logic                 Clock,
  input  logic                 Clear,
  alu_step_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef SINGLE_STEP_EN
    S_HOLD,
`endif
    S_FAULT
  } state_t;

  state_t            state_q, state_d, tgt;
  logic              advance;
  logic [WAIT_W-1:0] wait_q, wait_d;
`ifdef SINGLE_STEP_EN
  state_t            hold_next_q, hold_next_d;
`endif

  logic [OPC_W-1:0] opc;
  logic             is_rtype, is_imm, is_unary;

  assign opc      = bus.Instr[IR_W-1 -: OPC_W];
  assign is_rtype = (opc >= OPC_W'(3))  && (opc <= OPC_W'(10));
  assign is_imm   = (opc >= OPC_W'(11)) && (opc <= OPC_W'(13));
  assign is_unary = (opc == OPC_W'(16)) || (opc == OPC_W'(17));

  // Every T-state that may pause under single-step requests its successor via
  // tgt/advance; the tail of this block decides whether to detour through HOLD.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    wait_d  = wait_q;
    tgt     = state_q;
    advance = 1'b0;
`ifdef SINGLE_STEP_EN
    hold_next_d = hold_next_q;
`endif
    case (state_q)
      S_IDLE: if (bus.Run) state_d = S_T0;
      S_T0: begin
        tgt     = S_T1;
        advance = 1'b1;
      end
      S_T1: begin
        if (bus.MemReady) begin
          wait_d  = '0;
          tgt     = S_T2;
          advance = 1'b1;
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          wait_d  = '0;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_T2: begin
        tgt     = S_T3;
        advance = 1'b1;
      end
      S_T3: begin
        if (is_unary) begin
          tgt     = S_T5;
          advance = 1'b1;
        end else if (is_rtype || is_imm) begin
          tgt     = S_T4;
          advance = 1'b1;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: begin
        tgt     = S_T5;
        advance = 1'b1;
      end
      S_T5:    state_d = bus.Run ? S_T0 : S_IDLE;
`ifdef SINGLE_STEP_EN
      S_HOLD:  if (bus.Step) state_d = hold_next_q;
`endif
      S_FAULT: if (!bus.Run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
`ifdef SINGLE_STEP_EN
      state_d     = S_HOLD;
      hold_next_d = tgt;
`else
      state_d     = tgt;
`endif
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    if (Clear) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
`ifdef SINGLE_STEP_EN
      hold_next_q <= S_IDLE;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
`ifdef SINGLE_STEP_EN
      hold_next_q <= hold_next_d;
`endif
    end
  end

  // Moore decode: IR is only trusted from T3 on, so class decode is used in T3/T4 alone.
  always_comb begin
    bus.PCout   = 1'b0;  bus.MARin  = 1'b0;  bus.IncPC = 1'b0;  bus.Zin   = 1'b0;
    bus.Zlowout = 1'b0;  bus.PCin   = 1'b0;  bus.Read  = 1'b0;  bus.MDRin = 1'b0;
    bus.MDRout  = 1'b0;  bus.IRin   = 1'b0;  bus.Gra   = 1'b0;  bus.Grb   = 1'b0;
    bus.Grc     = 1'b0;  bus.Rin    = 1'b0;  bus.Rout  = 1'b0;  bus.Yin   = 1'b0;
    bus.Cout    = 1'b0;  bus.AluOp  = '0;    bus.Done  = 1'b0;
    bus.Busy    = (state_q != S_IDLE);
    bus.Fault   = (state_q == S_FAULT);
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;  bus.MARin = 1'b1;  bus.IncPC = 1'b1;  bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;  bus.Read = 1'b1;  bus.MDRin = 1'b1;
        bus.PCin    = (wait_q == '0);
      end
      S_T2: begin
        bus.MDRout = 1'b1;  bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_unary) begin
          bus.Grb = 1'b1;  bus.Rout = 1'b1;  bus.Zin = 1'b1;  bus.AluOp = opc;
        end else if (is_rtype || is_imm) begin
          bus.Grb = 1'b1;  bus.Rout = 1'b1;  bus.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_rtype) begin
          bus.Grc = 1'b1;  bus.Rout = 1'b1;  bus.Zin = 1'b1;  bus.AluOp = opc;
        end else if (is_imm) begin
          bus.Cout = 1'b1;  bus.Zin = 1'b1;  bus.AluOp = opc;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;  bus.Gra = 1'b1;  bus.Rin = 1'b1;  bus.Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
